wtree_mul_arb: RTL and testbench

Two-requester arbiter and sequencer for one shared Wallace-tree multiplier unit, whose column sub-trees take a held-high begin level and return an end pulse. Accepts operand pairs from two clients, grants round-robin, drives the unit's begin/operand inputs, waits for end (optionally with a timeout), and returns the product to the owning client over a valid/ready response channel. Sits between the issuing pipelines and the multiplier datapath.

---
 rtl/wtree_mul_arb_if.sv | 49 ++++
 rtl/wtree_mul_arb.sv | 153 +++++++++++++++
 tb/tb_wtree_mul_arb.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wtree_mul_arb_if.sv
// Bundle of client request/response channels and multiplier-unit signals for wtree_mul_arb.
// The slave modport is the arbiter's view; master is the view of the clients and the multiplier model.
interface wtree_mul_arb_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_x;
  logic [WIDTH-1:0]     req0_y;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_x;
  logic [WIDTH-1:0]     req1_y;

  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [2*WIDTH-1:0]   rsp_result;
  logic                 rsp_err;

  logic                 mul_begin;
  logic [WIDTH-1:0]     mul_x;
  logic [WIDTH-1:0]     mul_y;
  logic                 mul_end;
  logic [2*WIDTH-1:0]   mul_result;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output mul_begin, mul_x, mul_y,
    input  mul_end, mul_result
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  mul_begin, mul_x, mul_y,
    output mul_end, mul_result
  );
endinterface

// File: rtl/wtree_mul_arb.sv
// Round-robin two-client arbiter/sequencer for a shared Wallace-tree multiplier unit.
// Optional WAIT timeout enabled by defining WTREE_MUL_ARB_TIMEOUT_EN.
module wtree_mul_arb #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  wtree_mul_arb_if.slave  bus
);

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("wtree_mul_arb: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 owner_q, owner_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 grant0;
  logic                 grant1;
  logic                 accept;
  logic                 rsp_fire;

`ifdef WTREE_MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 expire;

  // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // With both valid, prio_q names the favoured client
  assign grant0   = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1   = bus.req1_valid & (~bus.req0_valid |  prio_q);
  assign accept   = (state_q == IDLE) & (grant0 | grant1);
  assign rsp_fire = (state_q == RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant1;
          x_d     = grant1 ? bus.req1_x : bus.req0_x;
          y_d     = grant1 ? bus.req1_y : bus.req0_y;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (bus.mul_end) begin
          result_d = bus.mul_result;
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
        end
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
        else if (expire) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
`endif
      end

      RESP: begin
        if (rsp_fire) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
`ifdef WTREE_MUL_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.req0_ready = (state_q == IDLE) & grant0;
  assign bus.req1_ready = (state_q == IDLE) & grant1;
  assign bus.rsp0_valid = (state_q == RESP) & ~owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &  owner_q;
  assign bus.rsp_result = result_q;
  assign bus.mul_begin  = (state_q == ISSUE) | (state_q == WAIT);
  assign bus.mul_x      = x_q;
  assign bus.mul_y      = y_q;

`ifdef WTREE_MUL_ARB_TIMEOUT_EN
  assign bus.rsp_err    = err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wtree_mul_arb.sv
// Directed bench for wtree_mul_arb: single request, round-robin contention, back-pressure,
// stray mul_end, mid-operation reset, and timeout / long-latency behaviour.
module tb_wtree_mul_arb;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  wtree_mul_arb_if #(.WIDTH(W)) bus ();

  wtree_mul_arb #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: end pulse on the end_delay-th cycle with begin high (0 = never)
  int unsigned end_delay = 7;
  int unsigned beg_cnt   = 0;
  bit          stray_end = 1'b0;

  always @(negedge clk) begin
    if (bus.mul_begin === 1'b1) beg_cnt++;
    else                        beg_cnt = 0;
    if (end_delay != 0 && beg_cnt == end_delay) begin
      bus.mul_end    = 1'b1;
      bus.mul_result = 32'(bus.mul_x) * 32'(bus.mul_y);
    end else if (stray_end) begin
      bus.mul_end    = 1'b1;
      bus.mul_result = 32'hDEAD_BEEF;
    end else begin
      bus.mul_end    = 1'b0;
      bus.mul_result = '0;
    end
  end

  // Shortest run of low mul_begin between two operations
  int unsigned low_run = 0;
  int unsigned min_gap = 1000;
  bit          had_op  = 1'b0;

  always @(negedge clk) begin
    if (bus.mul_begin === 1'b1) begin
      if (had_op && low_run != 0 && low_run < min_gap) min_gap = low_run;
      if (low_run == 0 && had_op) begin end
      had_op  = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input int port, input string tag, output int unsigned beg);
    bit seen;
    seen = 1'b0;
    beg  = 0;
    for (int i = 0; i < 400; i++) begin
      if (((port == 0) ? bus.rsp0_valid : bus.rsp1_valid) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.mul_begin === 1'b1) beg++;
      @(negedge clk);
    end
    check({tag, "_rsp_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned beg;
    bit          any_valid;

    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.mul_end    = 1'b0; bus.mul_result = '0;

    repeat (3) @(negedge clk);
    check("rst_mul_begin",  64'(bus.mul_begin),  64'd0);
    check("rst_mul_x",      64'(bus.mul_x),      64'd0);
    check("rst_mul_y",      64'(bus.mul_y),      64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_err",    64'(bus.rsp_err),    64'd0);
    check("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    rst = 1'b0;

    // Single request 3 x 5, end pulse six cycles after begin rises
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_x = 16'd3; bus.req0_y = 16'd5;
    #1;
    check("t1_req0_ready", 64'(bus.req0_ready), 64'd1);
    check("t1_req1_ready", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("t1_begin", 64'(bus.mul_begin), 64'd1);
    check("t1_mul_x", 64'(bus.mul_x),     64'd3);
    check("t1_mul_y", 64'(bus.mul_y),     64'd5);
    wait_rsp(0, "t1", beg);
    check("t1_begin_cycles", 64'(beg),            64'd7);
    check("t1_result",       64'(bus.rsp_result), 64'd15);
    check("t1_err",          64'(bus.rsp_err),    64'd0);
    check("t1_rsp1_valid",   64'(bus.rsp1_valid), 64'd0);
    check("t1_begin_low",    64'(bus.mul_begin),  64'd0);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    check("t1_rsp_done",    64'(bus.rsp0_valid), 64'd0);
    check("t1_result_hold", 64'(bus.rsp_result), 64'd15);

    // Contention from reset: req0 first, then req1 while both stay valid
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_x = 16'd7;     bus.req0_y = 16'd9;
    bus.req1_valid = 1'b1; bus.req1_x = 16'hFFFF;  bus.req1_y = 16'hFFFF;
    #1;
    check("c_r0_ready", 64'(bus.req0_ready), 64'd1);
    check("c_r1_ready", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    check("c0_mul_x", 64'(bus.mul_x), 64'd7);
    check("c0_mul_y", 64'(bus.mul_y), 64'd9);
    wait_rsp(0, "c0", beg);
    check("c0_result",     64'(bus.rsp_result), 64'd63);
    check("c0_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    bus.rsp0_ready = 1'b1;
    #1;
    check("c0_hs_r0_ready", 64'(bus.req0_ready), 64'd0);
    check("c0_hs_r1_ready", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("c_rr_r1_ready", 64'(bus.req1_ready), 64'd1);
    check("c_rr_r0_ready", 64'(bus.req0_ready), 64'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    check("c1_mul_x", 64'(bus.mul_x), 64'hFFFF);
    wait_rsp(1, "c1", beg);
    check("c1_result",     64'(bus.rsp_result), 64'hFFFE_0001);
    check("c1_err",        64'(bus.rsp_err),    64'd0);
    check("c1_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);

    // Back-pressure on rsp1 while req0 keeps its request up
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
      check("bp_result",     64'(bus.rsp_result), 64'hFFFE_0001);
      check("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp1_ready = 1'b1;
    #1;
    check("bp_hs_req0_ready", 64'(bus.req0_ready), 64'd0);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    check("bp_rsp1_done", 64'(bus.rsp1_valid), 64'd0);
    #1;
    check("bp_next_req0_ready", 64'(bus.req0_ready), 64'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("bp0_mul_x", 64'(bus.mul_x), 64'd7);
    wait_rsp(0, "bp0", beg);
    check("bp0_result", 64'(bus.rsp_result), 64'd63);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;

    // Stray mul_end while idle must be ignored
    stray_end = 1'b1;
    repeat (2) @(negedge clk);
    stray_end = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_begin",  64'(bus.mul_begin),                   64'd0);
    check("stray_valid",  64'(bus.rsp0_valid | bus.rsp1_valid), 64'd0);
    check("stray_result", 64'(bus.rsp_result),                  64'd63);

    // Reset two cycles into WAIT discards the operation
    bus.req1_valid = 1'b1; bus.req1_x = 16'd4; bus.req1_y = 16'd5;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    check("mr_issue_begin", 64'(bus.mul_begin), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_begin_low", 64'(bus.mul_begin),  64'd0);
    check("mr_rsp0",      64'(bus.rsp0_valid), 64'd0);
    check("mr_rsp1",      64'(bus.rsp1_valid), 64'd0);
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.mul_begin !== 1'b0) any_valid = 1'b1;
    end
    check("mr_quiet", 64'(any_valid), 64'd0);
    // prio was 1 before the reset; a cleared prio favours req0 again
    bus.req0_valid = 1'b1; bus.req0_x = 16'd6; bus.req0_y = 16'd7;
    bus.req1_valid = 1'b1; bus.req1_x = 16'd4; bus.req1_y = 16'd5;
    #1;
    check("mr_prio_r0_ready", 64'(bus.req0_ready), 64'd1);
    check("mr_prio_r1_ready", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_rsp(0, "mr0", beg);
    check("mr0_result", 64'(bus.rsp_result), 64'd42);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("mr1_req1_ready", 64'(bus.req1_ready), 64'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    check("mr1_mul_x", 64'(bus.mul_x), 64'd4);
    wait_rsp(1, "mr1", beg);
    check("mr1_result", 64'(bus.rsp_result), 64'd20);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;

`ifdef WTREE_MUL_ARB_TIMEOUT_EN
    // No end pulse: abort after 15 WAIT cycles (16 cycles with begin high)
    end_delay = 0;
    bus.req0_valid = 1'b1; bus.req0_x = 16'd3; bus.req0_y = 16'd5;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_rsp(0, "to", beg);
    check("to_begin_cycles", 64'(beg),            64'd16);
    check("to_result",       64'(bus.rsp_result), 64'd0);
    check("to_err",          64'(bus.rsp_err),    64'd1);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    // End pulse in the expiry cycle wins
    end_delay = 16;
    bus.req1_valid = 1'b1; bus.req1_x = 16'd2; bus.req1_y = 16'd9;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_rsp(1, "tx", beg);
    check("tx_begin_cycles", 64'(beg),            64'd16);
    check("tx_result",       64'(bus.rsp_result), 64'd18);
    check("tx_err",          64'(bus.rsp_err),    64'd0);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
`else
    // Long latency: no abort without the timeout feature
    end_delay = 101;
    bus.req0_valid = 1'b1; bus.req0_x = 16'h1234; bus.req0_y = 16'h0010;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_rsp(0, "ll", beg);
    check("ll_begin_cycles", 64'(beg),            64'd101);
    check("ll_result",       64'(bus.rsp_result), 64'h0001_2340);
    check("ll_err",          64'(bus.rsp_err),    64'd0);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("begin_gap_ge2", 64'(min_gap >= 2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
